// File: rtl/cobra_loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
package cobra_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    localparam int DEFAULT_MEM_WORDS = 128;

    function automatic logic [31:0] word_addr(input logic [15:0] idx);
        return {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid_o marks the
// cycle the fourth byte of a word is presented.
module word_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    // Earlier bytes shift down so byte 0 ends up in the least significant lane.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            shift_d = 24'd0;
            cnt_d   = 2'd0;
        end else if (en_i) begin
            shift_d = {byte_i, shift_q[23:8]};
            cnt_d   = cnt_q + 2'd1;
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
        end
    end

    // Byte lane register and counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= 24'd0;
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o       = {byte_i, shift_q};
    assign word_valid_o = en_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the
// core in reset until the whole image has been written.
module program_loader
    import cobra_loader_pkg::*;
#(
    parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        core_rst_q, core_rst_d;
    logic        byte_ready_q, byte_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept_s;
    logic        asm_en_s;
    logic        asm_clr_s;
    logic        word_valid_s;
    logic [31:0] word_s;
    logic [15:0] n_s;

    assign accept_s  = byte_valid_i && byte_ready_q;
    assign asm_en_s  = accept_s && (state_q == ST_DATA);
    assign asm_clr_s = (state_q != ST_DATA);
    assign n_s       = {byte_data_i, len_q[7:0]};

    word_assembler u_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (asm_clr_s),
        .en_i         (asm_en_s),
        .byte_i       (byte_data_i),
        .word_o       (word_s),
        .word_valid_o (word_valid_s)
    );

    // Next-state, counters and memory-port values; status outputs follow state_d
    // so their registered copies track the state register exactly.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d    = ST_LEN_LO;
                    len_d      = 16'd0;
                    word_idx_d = 16'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    len_d   = {len_q[15:8], byte_data_i};
                    state_d = ST_LEN_HI;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    len_d      = n_s;
                    word_idx_d = 16'd0;
                    if (n_s == 16'd0) begin
                        state_d = ST_DONE;
                    end else if (int'({16'd0, n_s}) > MEM_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA: begin
                if (word_valid_s) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_addr(word_idx_q);
                    mem_wdata_d = word_s;
                    // The index parks on N-1 so it never runs past the image.
                    if (word_idx_q == (len_q - 16'd1)) begin
                        state_d = ST_DONE;
                    end else begin
                        word_idx_d = word_idx_q + 16'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) || (state_d == ST_DATA);
        byte_ready_d = busy_d;
        done_d       = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERR);
        core_rst_d   = (state_d != ST_DONE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            len_q        <= 16'd0;
            word_idx_q   <= 16'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            core_rst_q   <= 1'b1;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rst_q   <= core_rst_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign core_rst_o   = core_rst_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised and directed bench for program_loader against a word-list model.
module tb_program_loader;

    localparam int MW = 128;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        core_rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic        got_done[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    always #5 clk = ~clk;

    program_loader #(.MEM_WORDS(MW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .core_rst_o   (core_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    // Every cycle with the strobe high is one memory write.
    always @(negedge clk) begin
        if (mem_we_o) begin
            got_addr.push_back(mem_addr_o);
            got_data.push_back(mem_wdata_o);
            got_done.push_back(done_o);
        end
    end

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
        got_done.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        byte_valid_i = 1'b0;
        repeat (stall) @(negedge clk);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        checks++;
        if (byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL byte_ready: got %b want 1 for byte %02h", byte_ready_o, b);
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    // Model: a stream of N words writes word i to byte address 4*i, unless N is
    // zero or larger than the memory.
    task automatic feed_stream(input int n, input logic [31:0] w[$], input int smin, input int smax);
        logic [15:0] len;
        logic [31:0] cur;
        len = 16'(n);
        if (n > 0 && n <= MW) begin
            foreach (w[i]) begin
                exp_addr.push_back(32'(i) * 32'd4);
                exp_data.push_back(w[i]);
            end
        end
        send_byte(len[7:0], $urandom_range(smax, smin));
        send_byte(len[15:8], $urandom_range(smax, smin));
        foreach (w[i]) begin
            cur = w[i];
            for (int k = 0; k < 4; k++) send_byte(cur[8*k +: 8], $urandom_range(smax, smin));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i        = 1'b1;
        start_i      = 1'b1;
        byte_valid_i = 1'b1;
        byte_data_i  = 8'h55;
        repeat (2) @(negedge clk);
        checks++;
        if ({core_rst_o, busy_o, done_o, err_o, byte_ready_o, mem_we_o} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 100000", {core_rst_o, busy_o, done_o, err_o, byte_ready_o, mem_we_o});
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o} !== 64'd0) begin
            errors++;
            $display("FAIL reset_mem_port: got %h/%h want 0/0", mem_addr_o, mem_wdata_o);
        end
        rst_i = 1'b0; start_i = 1'b0; byte_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_o, byte_ready_o, core_rst_o} !== 3'b001) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 001", {busy_o, byte_ready_o, core_rst_o});
        end
    endtask

    task automatic test_two_words();
        logic [31:0] w[$];
        w = '{32'h00100013, 32'h00200093};
        clear_log();
        pulse_start();
        feed_stream(2, w, 0, 0);
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL two_words_count: got %0d want %0d", got_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                checks++;
                if ({got_addr[i], got_data[i], got_done[i]} !== {exp_addr[i], exp_data[i], (i == exp_addr.size() - 1)}) begin
                    errors++;
                    $display("FAIL two_words_write%0d: got %h/%h done=%b want %h/%h", i, got_addr[i], got_data[i], got_done[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        checks++;
        if ({done_o, core_rst_o, busy_o, err_o} !== 4'b1000) begin
            errors++;
            $display("FAIL two_words_done: got %b want 1000", {done_o, core_rst_o, busy_o, err_o});
        end
    endtask

    task automatic test_zero_len();
        logic [31:0] w[$];
        clear_log();
        pulse_start();
        feed_stream(0, w, 0, 2);
        checks++;
        if (got_addr.size() != 0 || done_o !== 1'b1 || core_rst_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: got writes=%0d done=%b core_rst=%b want 0/1/0", got_addr.size(), done_o, core_rst_o);
        end
    endtask

    task automatic test_too_long();
        logic [31:0] w[$];
        clear_log();
        pulse_start();
        feed_stream(MW + 1, w, 0, 0);
        checks++;
        if ({err_o, byte_ready_o, done_o, core_rst_o, busy_o} !== 5'b10010) begin
            errors++;
            $display("FAIL too_long_err: got %b want 10010", {err_o, byte_ready_o, done_o, core_rst_o, busy_o});
        end
        byte_valid_i = 1'b1;
        byte_data_i  = 8'h13;
        repeat (3) @(negedge clk);
        byte_valid_i = 1'b0;
        checks++;
        if (got_addr.size() != 0 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL too_long_hold: got writes=%0d err=%b want 0/1", got_addr.size(), err_o);
        end
        pulse_start();
        checks++;
        if ({busy_o, byte_ready_o, err_o} !== 3'b110) begin
            errors++;
            $display("FAIL err_restart: got %b want 110", {busy_o, byte_ready_o, err_o});
        end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_stalls();
        logic [31:0] w[$];
        w = '{32'hDEADBEEF};
        clear_log();
        pulse_start();
        feed_stream(1, w, 5, 5);
        checks++;
        if (got_addr.size() != 1) begin
            errors++;
            $display("FAIL stall_count: got %0d want 1", got_addr.size());
        end else if ({got_addr[0], got_data[0], got_done[0]} !== {32'h0, 32'hDEADBEEF, 1'b1}) begin
            errors++;
            $display("FAIL stall_write: got %h/%h done=%b want 0/deadbeef", got_addr[0], got_data[0], got_done[0]);
        end
    endtask

    task automatic test_reset_midload();
        logic [31:0] w[$];
        clear_log();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (got_addr.size() != 0 || {core_rst_o, busy_o, done_o} !== 3'b100) begin
            errors++;
            $display("FAIL midload_reset: got writes=%0d flags=%b want 0/100", got_addr.size(), {core_rst_o, busy_o, done_o});
        end
        w = '{32'hCAFEF00D};
        pulse_start();
        feed_stream(1, w, 0, 1);
        checks++;
        if (got_addr.size() != 1 || got_addr[0] !== 32'h0 || got_data[0] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL midload_fresh: got writes=%0d first=%h/%h want 1 0/cafef00d", got_addr.size(),
                     (got_addr.size() > 0) ? got_addr[0] : 32'hx, (got_data.size() > 0) ? got_data[0] : 32'hx);
        end
    endtask

    task automatic test_reload();
        logic [31:0] w[$];
        w = '{32'h12345678};
        clear_log();
        pulse_start();
        checks++;
        if ({core_rst_o, done_o, busy_o} !== 3'b101) begin
            errors++;
            $display("FAIL reload_core_rst: got %b want 101", {core_rst_o, done_o, busy_o});
        end
        feed_stream(1, w, 0, 2);
        checks++;
        if (got_addr.size() != 1 || got_data[0] !== 32'h12345678 || got_addr[0] !== 32'h0 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL reload_write: got writes=%0d done=%b want 1 write at 0, done", got_addr.size(), done_o);
        end
    endtask

    task automatic test_boundary_and_random();
        logic [31:0] w[$];
        int n;
        for (int it = 0; it < 9; it++) begin
            n = (it == 0) ? MW : $urandom_range(10, 1);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom);
            clear_log();
            pulse_start();
            feed_stream(n, w, 0, (it == 0) ? 0 : 3);
            checks++;
            if (got_addr.size() != exp_addr.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d want %0d", it, got_addr.size(), exp_addr.size());
            end else begin
                foreach (exp_addr[i]) begin
                    checks++;
                    if ({got_addr[i], got_data[i], got_done[i]} !== {exp_addr[i], exp_data[i], (i == exp_addr.size() - 1)}) begin
                        errors++;
                        $display("FAIL rand%0d_write%0d: got %h/%h done=%b want %h/%h", it, i, got_addr[i], got_data[i], got_done[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            checks++;
            if ({done_o, core_rst_o, err_o} !== 3'b100) begin
                errors++;
                $display("FAIL rand%0d_done: got %b want 100", it, {done_o, core_rst_o, err_o});
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_data_i = 8'h00;
        @(negedge clk);
        test_reset();
        test_two_words();
        test_zero_len();
        test_too_long();
        test_stalls();
        test_reset_midload();
        test_reload();
        test_boundary_and_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEM_WORDS, default 128: instruction memory depth in 32-bit words.
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 start_i  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE and ERR.
REQ-005 byte_valid_i  input  1  source presents a byte this cycle.
REQ-006 byte_data_i  input  8  byte payload.
REQ-007 byte_ready_o  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid_i && byte_ready_o.
REQ-008 mem_we_o  output  1  one-cycle write strobe to the instruction memory write port.
REQ-009 mem_addr_o  output  32  word-aligned byte address, word_index*4.
REQ-010 mem_wdata_o  output  32  instruction word to write.
REQ-011 core_rst_o  output  1  hold-in-reset for the processor core.
REQ-012 busy_o  output  1  high in LEN_LO, LEN_HI and DATA.
REQ-013 done_o  output  1  high in DONE.
REQ-014 err_o  output  1  high in ERR.

Function
REQ-015 States: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR.
REQ-016 IDLE/DONE/ERR + start_i -> LEN_LO; start_i ignored in all other states.
REQ-017 Stream format: 16-bit word count N, low byte first, then 4*N instruction bytes.
REQ-018 LEN_LO: accepted byte -> N[7:0], go to LEN_HI.
REQ-019 LEN_HI: accepted byte -> N[15:8]; N==0 -> DONE; N>MEM_WORDS -> ERR; else -> DATA with word_index=0, byte_index=0.
REQ-020 Word assembly is little-endian: byte k of a word (k=0..3) lands in bits [8k+7:8k].
REQ-021 On acceptance of byte_index 3, mem_we_o pulses high exactly one cycle later, with mem_wdata_o = assembled word and mem_addr_o = word_index*4; mem_addr_o and mem_wdata_o are stable during that pulse.
REQ-022 word_index increments after each write; no wrap: it never exceeds N-1.
REQ-023 The write of word N-1 happens in the same cycle the FSM enters DONE.
REQ-024 byte_ready_o is high in LEN_LO, LEN_HI and DATA, and low in IDLE, DONE and ERR; bytes offered in IDLE, DONE or ERR are not consumed.
REQ-025 byte_valid_i low in any state: no state, index or data change (stalls of any length allowed).
REQ-026 core_rst_o is low only in DONE; it rises in the same cycle DONE exits on start_i (reload).
REQ-027 mem_we_o is never high outside the cycle defined in REQ-021.

Reset
REQ-028 rst_i high at a clock edge forces IDLE, word_index=0, byte_index=0, N=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, core_rst_o=1, byte_ready_o=0, busy_o=0, done_o=0, err_o=0.
REQ-029 Reset mid-load discards the partial word; no write strobe is issued for it. Already-written memory words are left unchanged.
REQ-030 rst_i has priority over start_i and byte transfers in the same cycle.

Structure
REQ-031 Shared package cobra_loader_pkg holds the state enum typedef and the default MEM_WORDS constant.
REQ-032 The byte-to-word shift register and the 2-bit byte counter form the sub-module word_assembler, which outputs the assembled word and a word_valid pulse. The FSM, counters and memory-port registers stay in program_loader.

Verification
REQ-033 Directed: start_i; bytes 02 00, then 13 00 10 00, then 93 00 20 00 -> mem_we_o pulses at addr 0x0 data 0x00100013 and addr 0x4 data 0x00200093; then DONE, core_rst_o=0.
REQ-034 Directed: start_i; bytes 00 00 -> DONE directly, no mem_we_o, done_o=1.
REQ-035 Directed: MEM_WORDS=128, length bytes 81 00 (129) -> ERR, err_o=1, byte_ready_o=0, no writes; later start_i -> LEN_LO.
REQ-036 Directed: N=1 with byte_valid_i low for 5 cycles between each byte -> single write, data 0xDEADBEEF from bytes EF BE AD DE.
REQ-037 Directed: rst_i asserted after 2 data bytes of word 0 -> IDLE, core_rst_o=1, no mem_we_o; a fresh load then writes from addr 0.
REQ-038 Directed: from DONE, start_i plus a new N=1 stream -> core_rst_o rises the same cycle, word rewritten at addr 0, DONE again.
